// File: rtl/lvds_rx20_align_ctrl.sv
// Purpose : training sequencer for the 20-channel LVDS receiver (PLL reset, lock wait, per-channel bit-slip alignment).
// Latency : lock seen 2 cycles after I_rx_locked; all-aligned run takes about PLL_RST_CYC+LOCK_STABLE+4+NCH*(SETTLE+MATCH_CNT+1) cycles.
// Backpres: none; I_start is ignored while O_busy is high.
//
// Ports: I_clk/I_rst_n clock and async active-low reset; I_start training request;
//   I_rx_locked async PLL lock; I_rx_out NCH*W receiver words (channel c at [c*W +: W]);
//   O_pll_areset, O_rx_cda_reset, O_rx_cda receiver controls; O_cda_rdy demux qualifier;
//   O_busy, O_done, O_fail (per channel), O_lock_fail status.
// Option: define ALIGN_CTRL_RELOCK_EN to retrain automatically on lock loss in DONE;
//   otherwise lock loss in DONE sets O_lock_fail and waits for I_start.
module lvds_rx20_align_ctrl #(
  parameter int             NCH         = 20,
  parameter int             W           = 10,
  parameter logic [W-1:0]   TRAIN_PAT   = 10'h3F0,
  parameter int             PLL_RST_CYC = 16,
  parameter int             LOCK_STABLE = 64,
  parameter int             LOCK_TO     = 4096,
  parameter int             SETTLE      = 8,
  parameter int             MATCH_CNT   = 8
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic               I_rx_locked,
  input  logic [NCH*W-1:0]   I_rx_out,
  output logic               O_pll_areset,
  output logic [NCH-1:0]     O_rx_cda_reset,
  output logic [NCH-1:0]     O_rx_cda,
  output logic               O_cda_rdy,
  output logic               O_busy,
  output logic               O_done,
  output logic [NCH-1:0]     O_fail,
  output logic               O_lock_fail
);

  localparam int CW  = $clog2(LOCK_TO + 1);
  localparam int SW  = $clog2(LOCK_STABLE + 1);
  localparam int MW  = $clog2(MATCH_CNT + 1);
  localparam int LW  = $clog2(W + 1);
  localparam int CHW = $clog2(NCH);

  typedef enum logic [3:0] {
    S_IDLE, S_PLL_RST, S_WAIT_LOCK, S_CDA_RST, S_SETTLE,
    S_CHECK, S_SLIP, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    slip_q, slip_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [1:0]       retry_q, retry_d;
  logic [NCH-1:0]   fail_q, fail_d;
  logic             lock_fail_q, lock_fail_d;
  logic             done_q, done_d, busy_q, busy_d, rdy_q, rdy_d;
  logic             pll_q;
  logic [NCH-1:0]   cda_rst_q, cda_q, cda_d;
  logic             lock_meta, lock_sync, lock_prev, lock_drop;
  logic             train_active, start_ok;
  logic [W-1:0]     ch_word;

  // Two-flop synchroniser; lock_prev gives a falling-edge detect for DONE.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      lock_prev <= 1'b0;
    end else begin
      lock_meta <= I_rx_locked;
      lock_sync <= lock_meta;
      lock_prev <= lock_sync;
    end
  end

  assign lock_drop    = lock_prev && !lock_sync;
  assign train_active = state_q inside {S_CDA_RST, S_SETTLE, S_CHECK, S_SLIP, S_NEXT};
  // A lock drop in DONE wins over a coincident start request.
  assign start_ok     = I_start && ((state_q == S_IDLE) || (state_q == S_DONE && !lock_drop));

  always_comb begin
    ch_word = '0;
    for (int c = 0; c < NCH; c++)
      if (ch_q == CHW'(c)) ch_word = I_rx_out[c*W +: W];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    match_d     = match_q;
    slip_d      = slip_q;
    ch_d        = ch_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    lock_fail_d = lock_fail_q;
    done_d      = done_q;
    busy_d      = busy_q;
    rdy_d       = rdy_q && lock_sync;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CW'(PLL_RST_CYC - 1)) begin
          cnt_d   = '0;
          stab_d  = '0;
          state_d = S_WAIT_LOCK;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WAIT_LOCK: begin
        cnt_d  = cnt_q + CW'(1);
        stab_d = lock_sync ? stab_q + SW'(1) : '0;
        if (lock_sync && stab_q == SW'(LOCK_STABLE - 1)) begin
          cnt_d   = '0;
          state_d = S_CDA_RST;
        end else if (cnt_q == CW'(LOCK_TO - 1)) begin
          cnt_d = '0;
          if (retry_q == 2'd2) begin
            lock_fail_d = 1'b1;
            fail_d      = '1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            rdy_d       = 1'b0;
            state_d     = S_DONE;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = S_PLL_RST;
          end
        end
      end
      S_CDA_RST: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          ch_d    = '0;
          slip_d  = '0;
          state_d = S_SETTLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          match_d = '0;
          state_d = S_CHECK;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_CHECK: begin
        if (ch_word == TRAIN_PAT) begin
          if (match_q == MW'(MATCH_CNT - 1)) state_d = S_NEXT;
          else match_d = match_q + MW'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_SLIP;
        end
      end
      S_SLIP: begin
        if (cnt_q == CW'(1)) begin
          cnt_d  = '0;
          slip_d = slip_q + LW'(1);
          if (slip_q == LW'(W - 1)) begin
            fail_d[ch_q] = 1'b1;
            state_d      = S_NEXT;
          end else state_d = S_SETTLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_NEXT: begin
        if (ch_q == CHW'(NCH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdy_d   = (fail_q == '0) && !lock_fail_q;
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          slip_d  = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        if (lock_drop) begin
          rdy_d = 1'b0;
`ifdef ALIGN_CTRL_RELOCK_EN
          done_d  = 1'b0;
          busy_d  = 1'b1;
          retry_d = '0;
          cnt_d   = '0;
          state_d = S_PLL_RST;
`else
          lock_fail_d = 1'b1;
`endif
        end
      end
      default: ;
    endcase

    if (start_ok) begin
      fail_d      = '0;
      lock_fail_d = 1'b0;
      done_d      = 1'b0;
      rdy_d       = 1'b0;
      busy_d      = 1'b1;
      retry_d     = '0;
      cnt_d       = '0;
      state_d     = S_PLL_RST;
    end

    // Lock loss during alignment discards this pass and restarts from the PLL reset.
    if (train_active && !lock_sync) begin
      fail_d  = fail_q;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      rdy_d   = 1'b0;
      cnt_d   = '0;
      state_d = S_PLL_RST;
    end
  end

  always_comb begin
    cda_d = '0;
    if (state_d == S_SLIP) cda_d[ch_d] = 1'b1;
  end

  // Receiver controls are registered from next-state so they are glitch-free.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stab_q      <= '0;
      match_q     <= '0;
      slip_q      <= '0;
      ch_q        <= '0;
      retry_q     <= '0;
      fail_q      <= '0;
      lock_fail_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
      pll_q       <= 1'b1;
      cda_rst_q   <= '0;
      cda_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      match_q     <= match_d;
      slip_q      <= slip_d;
      ch_q        <= ch_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      lock_fail_q <= lock_fail_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
      // IDLE is only reachable from reset, where the PLL stays held.
      pll_q       <= (state_d == S_PLL_RST) || (state_d == S_IDLE && pll_q);
      cda_rst_q   <= {NCH{state_d == S_CDA_RST}};
      cda_q       <= cda_d;
    end
  end

  assign O_pll_areset   = pll_q;
  assign O_rx_cda_reset = cda_rst_q;
  assign O_rx_cda       = cda_q;
  assign O_cda_rdy      = rdy_q;
  assign O_busy         = busy_q;
  assign O_done         = done_q;
  assign O_fail         = fail_q;
  assign O_lock_fail    = lock_fail_q;

endmodule

// File: tb/tb_lvds_rx20_align_ctrl.sv
// Purpose : self-checking bench for lvds_rx20_align_ctrl with a receiver/PLL model and a result scoreboard.
// Latency : each training run is checked when O_done rises.
// Backpres: none.
module tb_lvds_rx20_align_ctrl;
  localparam int NCH = 20;
  localparam int W   = 10;
  localparam logic [W-1:0] PAT = 10'h3F0;

  logic               I_clk = 1'b0;
  logic               I_rst_n, I_start, I_rx_locked;
  logic [NCH*W-1:0]   I_rx_out;
  logic               O_pll_areset, O_cda_rdy, O_busy, O_done, O_lock_fail;
  logic [NCH-1:0]     O_rx_cda_reset, O_rx_cda, O_fail;

  lvds_rx20_align_ctrl dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .I_rx_locked(I_rx_locked),
    .I_rx_out(I_rx_out), .O_pll_areset(O_pll_areset), .O_rx_cda_reset(O_rx_cda_reset),
    .O_rx_cda(O_rx_cda), .O_cda_rdy(O_cda_rdy), .O_busy(O_busy), .O_done(O_done),
    .O_fail(O_fail), .O_lock_fail(O_lock_fail)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    int             id;
    logic           rdy;
    logic [NCH-1:0] fail;
    logic           lfail;
    int             falls;
    int             pulses;
    int             ch;
    int             ch_pulses;
    int             rst_cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, failures = 0;

  // Receiver / PLL model state
  int rot[NCH];
  bit stuck[NCH];
  int pulses[NCH], base_pulses[NCH], plen[NCH];
  logic [NCH-1:0] cda_prev = '0;
  int pll_falls = 0, base_falls = 0, cdarst_cyc = 0, base_rst = 0;
  int bad_len = 0, excl = 0, lcnt = 0, drop_cnt = 0;
  bit hold_low = 1'b0;
  logic pll_prev = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [W-1:0] x;
    x = v;
    for (int i = 0; i < r; i++) x = {x[W-2:0], x[W-1]};
    return x;
  endfunction

  // Model updates 2 time units after each rising edge, sampling the registered DUT controls.
  always @(posedge I_clk) begin
    #2;
    if (pll_prev && !O_pll_areset) pll_falls++;
    pll_prev = O_pll_areset;
    if (O_pll_areset || hold_low) begin
      lcnt = 0;
      I_rx_locked = 1'b0;
    end else if (drop_cnt > 0) begin
      drop_cnt--;
      I_rx_locked = 1'b0;
    end else begin
      if (lcnt < 10) lcnt++;
      I_rx_locked = (lcnt >= 10);
    end
    for (int c = 0; c < NCH; c++) begin
      if (O_rx_cda[c]) begin
        if (!cda_prev[c]) begin
          pulses[c]++;
          rot[c] = (rot[c] == 0) ? W - 1 : rot[c] - 1;
        end
        plen[c]++;
      end else begin
        if (cda_prev[c] && plen[c] != 2) bad_len++;
        plen[c] = 0;
      end
    end
    cda_prev = O_rx_cda;
    if ($countones(O_rx_cda) > 1 || (|O_rx_cda && |O_rx_cda_reset)) excl++;
    if (|O_rx_cda_reset) cdarst_cyc++;
    for (int c = 0; c < NCH; c++)
      I_rx_out[c*W +: W] = stuck[c] ? '0 : rotl(PAT, rot[c]);
  end

  task automatic set_chans(input int rch, input int r, input int sch);
    for (int c = 0; c < NCH; c++) begin
      rot[c]   = (c == rch) ? r : 0;
      stuck[c] = (c == sch);
    end
  endtask

  task automatic arm(input exp_t e);
    for (int c = 0; c < NCH; c++) base_pulses[c] = pulses[c];
    base_falls = pll_falls;
    base_rst   = cdarst_cyc;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge I_clk); I_start = 1'b1;
    @(negedge I_clk); I_start = 1'b0;
  endtask

  task automatic finish_case(input int budget);
    exp_t e;
    int n, tot;
    string t;
    n = 0;
    while (O_done !== 1'b1 && n < budget) begin
      @(negedge I_clk);
      n++;
    end
    e = sb_q.pop_front();
    t = $sformatf("t%0d", e.id);
    check_eq({t, "_done_seen"}, {31'b0, O_done}, 32'd1);
    tot = 0;
    for (int c = 0; c < NCH; c++) tot += pulses[c] - base_pulses[c];
    check_eq({t, "_cda_rdy"},   {31'b0, O_cda_rdy}, {31'b0, e.rdy});
    check_eq({t, "_fail"},      32'(O_fail), 32'(e.fail));
    check_eq({t, "_lock_fail"}, {31'b0, O_lock_fail}, {31'b0, e.lfail});
    check_eq({t, "_busy"},      {31'b0, O_busy}, 32'd0);
    check_eq({t, "_pll_rsts"},  pll_falls - base_falls, e.falls);
    check_eq({t, "_pulses"},    tot, e.pulses);
    check_eq({t, "_ch_pulses"}, pulses[e.ch] - base_pulses[e.ch], e.ch_pulses);
    check_eq({t, "_cdarst_cyc"}, cdarst_cyc - base_rst, e.rst_cyc);
  endtask

  initial begin
    exp_t e;
    int n;
    for (int c = 0; c < NCH; c++) begin
      rot[c] = 0; stuck[c] = 1'b0; pulses[c] = 0; base_pulses[c] = 0; plen[c] = 0;
    end
    I_rst_n = 1'b0; I_start = 1'b0; I_rx_locked = 1'b0; I_rx_out = {NCH{PAT}};
    repeat (3) @(negedge I_clk);
    I_rst_n = 1'b1;
    @(negedge I_clk);

    check_eq("rst_pll_areset", {31'b0, O_pll_areset}, 32'd1);
    check_eq("rst_cda_reset",  32'(O_rx_cda_reset), 32'd0);
    check_eq("rst_cda",        32'(O_rx_cda), 32'd0);
    check_eq("rst_cda_rdy",    {31'b0, O_cda_rdy}, 32'd0);
    check_eq("rst_busy",       {31'b0, O_busy}, 32'd0);
    check_eq("rst_done",       {31'b0, O_done}, 32'd0);
    check_eq("rst_fail",       32'(O_fail), 32'd0);
    check_eq("rst_lock_fail",  {31'b0, O_lock_fail}, 32'd0);

    // 1: all aligned; a second start while busy must be ignored.
    set_chans(-1, 0, -1);
    e = '{id:1, rdy:1, fail:'0, lfail:0, falls:1, pulses:0, ch:0, ch_pulses:0, rst_cyc:2};
    arm(e); pulse_start();
    repeat (40) @(negedge I_clk);
    check_eq("t1_busy_mid", {31'b0, O_busy}, 32'd1);
    pulse_start();
    finish_case(3000);

    // 2: channel 5 rotated by 3 -> three slips.
    set_chans(5, 3, -1);
    e = '{id:2, rdy:1, fail:'0, lfail:0, falls:1, pulses:3, ch:5, ch_pulses:3, rst_cyc:2};
    arm(e); pulse_start(); finish_case(3000);

    // 3: channel 12 stuck at zero -> ten slips and a channel failure.
    set_chans(-1, 0, 12);
    e = '{id:3, rdy:0, fail:20'h01000, lfail:0, falls:1, pulses:10, ch:12, ch_pulses:10, rst_cyc:2};
    arm(e); pulse_start(); finish_case(4000);

    // 4: lock never arrives -> three PLL resets then lock failure.
    set_chans(-1, 0, -1);
    hold_low = 1'b1;
    e = '{id:4, rdy:0, fail:'1, lfail:1, falls:3, pulses:0, ch:0, ch_pulses:0, rst_cyc:0};
    arm(e); pulse_start(); finish_case(14000);
    hold_low = 1'b0;

    // 5: lock drops for 4 cycles while channel 7 is being compared after its slip.
    set_chans(7, 1, -1);
    e = '{id:5, rdy:1, fail:'0, lfail:0, falls:2, pulses:1, ch:7, ch_pulses:1, rst_cyc:4};
    arm(e); pulse_start();
    n = 0;
    while (O_rx_cda[7] !== 1'b1 && n < 3000) begin @(negedge I_clk); n++; end
    while (O_rx_cda[7] !== 1'b0 && n < 3000) begin @(negedge I_clk); n++; end
    check_eq("t5_ch7_slip_seen", {31'b0, n < 3000}, 32'd1);
    repeat (9) @(negedge I_clk);
    drop_cnt = 4;
    finish_case(3000);

    // 6: lock drops in DONE; cda_rdy falls 3 cycles after the sync delay starts.
`ifdef ALIGN_CTRL_RELOCK_EN
    e = '{id:6, rdy:1, fail:'0, lfail:0, falls:1, pulses:0, ch:0, ch_pulses:0, rst_cyc:2};
    arm(e);
`endif
    drop_cnt = 4;
    repeat (3) @(negedge I_clk);
    check_eq("t6_rdy_before_sync", {31'b0, O_cda_rdy}, 32'd1);
    @(negedge I_clk);
    check_eq("t6_rdy_fall", {31'b0, O_cda_rdy}, 32'd0);
`ifdef ALIGN_CTRL_RELOCK_EN
    check_eq("t6_relock_busy", {31'b0, O_busy}, 32'd1);
    check_eq("t6_relock_done", {31'b0, O_done}, 32'd0);
    finish_case(3000);
`else
    check_eq("t6_lock_fail", {31'b0, O_lock_fail}, 32'd1);
    repeat (20) @(negedge I_clk);
    check_eq("t6_stay_done",  {31'b0, O_done}, 32'd1);
    check_eq("t6_stay_idle",  {31'b0, O_busy}, 32'd0);
    check_eq("t6_pll_free",   {31'b0, O_pll_areset}, 32'd0);
    check_eq("t6_rdy_low",    {31'b0, O_cda_rdy}, 32'd0);
    // 7: a fresh start recovers and clears the sticky lock failure.
    e = '{id:7, rdy:1, fail:'0, lfail:0, falls:1, pulses:0, ch:0, ch_pulses:0, rst_cyc:2};
    arm(e); pulse_start(); finish_case(3000);
`endif

    check_eq("pulse_len_2", bad_len, 0);
    check_eq("cda_exclusive", excl, 0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
